// File: rtl/float_normalizer_if.sv
// -----------------------------------------------------------------------------
// float_normalizer_if
// Handshake bundle for the float_normalizer stage.
//
// Valid/ready rule for both sides: a word moves on a rising clock edge where
// valid and ready are both high. The producer holds valid and its payload
// steady until that edge; ready may be dropped by the consumer at any time.
//
//   input side  : i_valid, i_sign, i_exp, i_mant (producer -> stage), o_ready
//   output side : o_valid, o_float, o_ovf, o_unf (stage -> consumer), i_ready
//
// master : upstream producer / downstream consumer (testbench side)
// slave  : the normalizer itself
// -----------------------------------------------------------------------------
interface float_normalizer_if #(
    parameter int NB_EXPONENTE = 4,
    parameter int NB_MANTISA   = 8,
    parameter int NB_EXP_IN    = 7
);
    logic                                 i_valid;
    logic                                 o_ready;
    logic                                 i_sign;
    logic signed [NB_EXP_IN-1:0]          i_exp;
    logic [2*(NB_MANTISA+1)-1:0]          i_mant;
    logic                                 o_valid;
    logic                                 i_ready;
    logic [NB_EXPONENTE+NB_MANTISA:0]     o_float;
    logic                                 o_ovf;
    logic                                 o_unf;

    modport master (
        output i_valid, i_sign, i_exp, i_mant, i_ready,
        input  o_ready, o_valid, o_float, o_ovf, o_unf
    );

    modport slave (
        input  i_valid, i_sign, i_exp, i_mant, i_ready,
        output o_ready, o_valid, o_float, o_ovf, o_unf
    );
endinterface

// File: rtl/float_normalizer.sv
// -----------------------------------------------------------------------------
// float_normalizer
// Normalize / round-to-nearest-even / pack stage for the custom float format
// {sign, NB_EXPONENTE exponent bits, NB_MANTISA fraction bits}. Takes the raw
// multiplier result (sign, signed biased exponent, full significand product)
// and left-normalizes it one bit per cycle before rounding and packing.
//
// Ports:
//   clock        rising-edge clock
//   i_reset      asynchronous reset, active low
//   bus          float_normalizer_if.slave (input and output handshakes)
//   o_dbg_state  current FSM state (IDLE=0, SHIFT=1, ROUND=2, OUT=3)
// -----------------------------------------------------------------------------
module float_normalizer #(
    parameter int NB_EXPONENTE = 4,
    parameter int NB_MANTISA   = 8,
    parameter int NB_EXP_IN    = 7
) (
    input  logic                  clock,
    input  logic                  i_reset,
    float_normalizer_if.slave     bus,
    output logic [1:0]            o_dbg_state
);
    localparam int H  = 2 * NB_MANTISA;          // hidden-bit position
    localparam int MW = 2 * (NB_MANTISA + 1);    // significand product width
    localparam int EW = NB_EXP_IN + 1;           // internal exponent width
    localparam int FW = 1 + NB_EXPONENTE + NB_MANTISA;
    localparam int CW = $clog2(H + 1);

    localparam logic [CW-1:0]        H_CNT    = CW'(H);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 ** NB_EXPONENTE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                  state_q, state_nx;
    logic                    sign_q;
    logic signed [EW-1:0]    exp_q;
    logic [MW-1:0]           mant_q;
    logic                    sticky_q;
    logic                    zero_q;
    logic [CW-1:0]           cnt_q;
    logic [FW-1:0]           float_q;
    logic                    ovf_q;
    logic                    unf_q;

    // Normalization is complete once the leading one sits at H or above,
    // the product is zero, or the left-shift budget is used up.
    logic shift_done;
    assign shift_done = (mant_q == '0) || mant_q[H+1] || mant_q[H] || (cnt_q == H_CNT);

    // ---------------- rounding / classification ----------------
    logic [NB_MANTISA-1:0]   frac;
    logic                    guard;
    logic                    sticky_all;
    logic                    round_up;
    logic [NB_MANTISA:0]     frac_sum;
    logic signed [EW-1:0]    exp_rnd;
    logic [FW-1:0]           res_float;
    logic                    res_ovf;
    logic                    res_unf;

    always_comb begin
        frac       = mant_q[H-1:NB_MANTISA];
        guard      = mant_q[NB_MANTISA-1];
        sticky_all = sticky_q | (|mant_q[NB_MANTISA-2:0]);
        // Nearest-even: ties go up only when the kept LSB is odd.
        round_up   = guard & (sticky_all | frac[0]);
        frac_sum   = {1'b0, frac} + {{NB_MANTISA{1'b0}}, round_up};
        // A carry out of the fraction means 1.11..1 rounded to 10.0: bump exponent.
        exp_rnd    = exp_q + {{(EW-1){1'b0}}, frac_sum[NB_MANTISA]};
        res_float  = '0;
        res_ovf    = 1'b0;
        res_unf    = 1'b0;
        if (zero_q) begin
            res_float = {sign_q, {(FW-1){1'b0}}};
        end else if (exp_rnd >= EXP_MAX) begin
            res_float = {sign_q, {(FW-1){1'b1}}};
            res_ovf   = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
            res_float = {sign_q, {(FW-1){1'b0}}};
            res_unf   = 1'b1;
        end else begin
            res_float = {sign_q, exp_rnd[NB_EXPONENTE-1:0], frac_sum[NB_MANTISA-1:0]};
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) state_q <= S_IDLE;
        else          state_q <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE:  if (bus.i_valid) state_nx = S_SHIFT;
            S_SHIFT: if (shift_done)  state_nx = S_ROUND;
            S_ROUND: state_nx = S_OUT;
            S_OUT:   if (bus.i_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.o_ready = (state_q == S_IDLE);
        bus.o_valid = (state_q == S_OUT);
        bus.o_float = float_q;
        bus.o_ovf   = ovf_q;
        bus.o_unf   = unf_q;
        o_dbg_state = state_q;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            sticky_q <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
            float_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        sign_q   <= bus.i_sign;
                        exp_q    <= {bus.i_exp[NB_EXP_IN-1], bus.i_exp};
                        mant_q   <= bus.i_mant;
                        sticky_q <= 1'b0;
                        zero_q   <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                S_SHIFT: begin
                    if (mant_q == '0) begin
                        zero_q <= 1'b1;
                    end else if (mant_q[H+1]) begin
                        // Product in [2,4): one right shift, keep the lost bit as sticky.
                        mant_q   <= mant_q >> 1;
                        sticky_q <= sticky_q | mant_q[0];
                        exp_q    <= exp_q + EXP_ONE;
                    end else if (!mant_q[H] && (cnt_q != H_CNT)) begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - EXP_ONE;
                        cnt_q  <= cnt_q + CNT_ONE;
                    end
                end
                S_ROUND: begin
                    float_q <= res_float;
                    ovf_q   <= res_ovf;
                    unf_q   <= res_unf;
                end
                S_OUT: begin
                    if (bus.i_ready) begin
                        ovf_q <= 1'b0;
                        unf_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
